// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the prefetch path: physical address width,
// prefetch FSM states and the IP advance rule for one bus word.
package cpu_pkg;

    localparam int PHYS_ADDR_W = 20;

    typedef enum logic [0:0] {
        PF_IDLE = 1'b0,
        PF_REQ  = 1'b1
    } prefetch_state_t;

    // An even IP consumes a whole word (two bytes); an odd IP only its upper byte.
    function automatic logic [15:0] ip_step(input logic [15:0] ip);
        return ip + (ip[0] ? 16'd1 : 16'd2);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Byte queue between the bus and the decoder: 1- or 2-byte push, 1-byte pop,
// synchronous flush. Depth need not be a power of two.
module prefetch_fifo #(
    parameter int FIFO_DEPTH = 6,
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             push_two,
    input  logic [7:0]       push_byte0,
    input  logic [7:0]       push_byte1,
    input  logic             pop,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_r;

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [PTR_W-1:0] wr_ptr1_s;
    logic [PTR_W-1:0] wr_ptr2_s;
    logic [PTR_W-1:0] rd_ptr1_s;
    logic [CNT_W-1:0] add_s;
    logic [CNT_W-1:0] sub_s;
    logic [CNT_W-1:0] count_next_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Push/pop qualification, pointer advance and next occupancy.
    always_comb begin
        push_ok_s = push & ~flush;
        pop_ok_s  = pop & ~empty_r & ~flush;
        wr_ptr1_s = ptr_inc(wr_ptr_r);
        wr_ptr2_s = ptr_inc(wr_ptr1_s);
        rd_ptr1_s = ptr_inc(rd_ptr_r);
        if (push_ok_s) begin
            add_s = push_two ? CNT_W'(2) : CNT_W'(1);
        end else begin
            add_s = CNT_W'(0);
        end
        sub_s = pop_ok_s ? CNT_W'(1) : CNT_W'(0);
        if (flush) begin
            count_next_s = CNT_W'(0);
        end else begin
            count_next_s = count_r + add_s - sub_s;
        end
    end

    // Pointers, occupancy and registered empty flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            empty_r  <= 1'b1;
        end else if (flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= push_two ? wr_ptr2_s : wr_ptr1_s;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr1_s;
            end
            count_r <= count_next_s;
            empty_r <= (count_next_s == CNT_W'(0));
        end
    end

    // Byte storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_byte0;
            if (push_two) begin
                mem_r[wr_ptr1_s] <= push_byte1;
            end
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/csip_prefetcher.sv
// Instruction prefetcher: fetches bytes at CS:IP over the 16-bit bus into a byte
// queue, and restarts atomically on a CS:IP load pulse from the sequencer.
module csip_prefetcher
    import cpu_pkg::*;
#(
    parameter int          FIFO_DEPTH = 6,
    parameter logic [15:0] RESET_CS   = 16'hFFFF,
    parameter logic [15:0] RESET_IP   = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_new_ip,
    input  logic [15:0]            new_cs,
    input  logic [15:0]            new_ip,
    output logic                   mem_access,
    input  logic                   mem_ack,
    output logic [PHYS_ADDR_W-2:0] mem_address,
    input  logic [15:0]            mem_data,
    input  logic                   fifo_rd_en,
    output logic [7:0]             fifo_rd_data,
    output logic [15:0]            fifo_rd_ip,
    output logic                   fifo_empty
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    prefetch_state_t        state_r;
    prefetch_state_t        state_next_s;
    logic [15:0]            fetch_cs_r;
    logic [15:0]            fetch_ip_r;
    logic [15:0]            rd_ip_r;
    logic                   abort_r;
    logic                   mem_access_r;
    logic [PHYS_ADDR_W-2:0] mem_address_r;

    logic [CNT_W-1:0]       count_s;
    logic [CNT_W-1:0]       free_s;
    logic                   empty_s;
    logic                   can_issue_s;
    logic                   issue_s;
    logic                   push_s;
    logic                   push_two_s;
    logic [7:0]             byte0_s;
    logic [7:0]             byte1_s;
    logic                   pop_ok_s;
    logic [PHYS_ADDR_W-2:0] word_addr_s;

    // Word address = ({cs,4'b0} + ip) >> 1; cs*16 is even so ip[0] drops out.
    assign word_addr_s = {fetch_cs_r, 3'b000} + {4'b0000, fetch_ip_r[15:1]};
    assign free_s      = CNT_W'(FIFO_DEPTH) - count_s;
    assign can_issue_s = ~load_new_ip & (free_s >= CNT_W'(2));

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= PF_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PF_IDLE: begin
                if (can_issue_s) begin
                    state_next_s = PF_REQ;
                end else begin
                    state_next_s = PF_IDLE;
                end
            end
            PF_REQ: begin
                if (mem_ack) begin
                    state_next_s = PF_IDLE;
                end else begin
                    state_next_s = PF_REQ;
                end
            end
            default: state_next_s = PF_IDLE;
        endcase
    end

    // FSM outputs: issue strobe, queue push control and pop qualification.
    always_comb begin
        issue_s    = (state_r == PF_IDLE) && (state_next_s == PF_REQ);
        push_two_s = ~fetch_ip_r[0];
        byte1_s    = mem_data[15:8];
        if (fetch_ip_r[0]) begin
            byte0_s = mem_data[15:8];
        end else begin
            byte0_s = mem_data[7:0];
        end
        if ((state_r == PF_REQ) && mem_ack && !abort_r && !load_new_ip) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_ok_s = fifo_rd_en & ~empty_s & ~load_new_ip;
    end

    // Bus request and address registers; address frozen for the whole request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_access_r  <= 1'b0;
            mem_address_r <= {(PHYS_ADDR_W-1){1'b0}};
        end else begin
            mem_access_r <= (state_next_s == PF_REQ);
            if (issue_s) begin
                mem_address_r <= word_addr_s;
            end
        end
    end

    // Fetch pointer, decoder-side IP and abort flag; a load overrides everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cs_r <= RESET_CS;
            fetch_ip_r <= RESET_IP;
            rd_ip_r    <= RESET_IP;
            abort_r    <= 1'b0;
        end else begin
            if (load_new_ip) begin
                fetch_cs_r <= new_cs;
                fetch_ip_r <= new_ip;
                rd_ip_r    <= new_ip;
            end else begin
                if (push_s) begin
                    fetch_ip_r <= ip_step(fetch_ip_r);
                end
                if (pop_ok_s) begin
                    rd_ip_r <= rd_ip_r + 16'd1;
                end
            end
            if ((state_r == PF_REQ) && mem_ack) begin
                abort_r <= 1'b0;
            end else if ((state_r == PF_REQ) && load_new_ip) begin
                abort_r <= 1'b1;
            end
        end
    end

    prefetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (load_new_ip),
        .push       (push_s),
        .push_two   (push_two_s),
        .push_byte0 (byte0_s),
        .push_byte1 (byte1_s),
        .pop        (fifo_rd_en),
        .rd_data    (fifo_rd_data),
        .empty      (empty_s),
        .count      (count_s)
    );

    assign mem_access  = mem_access_r;
    assign mem_address = mem_address_r;
    assign fifo_rd_ip  = rd_ip_r;
    assign fifo_empty  = empty_s;

endmodule

// File: tb/tb_csip_prefetcher.sv
// Self-checking bench for csip_prefetcher: directed scenarios plus random traffic,
// all compared every cycle against a queue-based model of the prefetcher.
module tb_csip_prefetcher;

    localparam int DEPTH = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_new_ip;
    logic [15:0] new_cs;
    logic [15:0] new_ip;
    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic [15:0] fifo_rd_ip;
    logic        fifo_empty;

    csip_prefetcher #(
        .FIFO_DEPTH (DEPTH),
        .RESET_CS   (16'hFFFF),
        .RESET_IP   (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_new_ip  (load_new_ip),
        .new_cs       (new_cs),
        .new_ip       (new_ip),
        .mem_access   (mem_access),
        .mem_ack      (mem_ack),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_ip   (fifo_rd_ip),
        .fifo_empty   (fifo_empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: outstanding request, its address, drop pending, pointers, byte queue.
    bit          m_req;
    bit          m_abort;
    logic [18:0] m_addr;
    logic [15:0] m_cs;
    logic [15:0] m_ip;
    logic [15:0] m_rd_ip;
    logic [7:0]  q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare at the next falling edge.
    task automatic tick(input bit ld, input logic [15:0] cs, input logic [15:0] ip,
                        input bit pop, input bit ack, input logic [15:0] data);
        int sz;
        int phys;
        sz = q.size();
        load_new_ip = ld;
        new_cs      = cs;
        new_ip      = ip;
        fifo_rd_en  = pop;
        mem_ack     = ack;
        mem_data    = data;
        if (ld) begin
            q.delete();
            m_rd_ip = ip;
            m_cs    = cs;
            m_ip    = ip;
            if (m_req && ack) begin
                m_req   = 1'b0;
                m_abort = 1'b0;
            end else if (m_req) begin
                m_abort = 1'b1;
            end
        end else begin
            if (pop && sz > 0) begin
                void'(q.pop_front());
                m_rd_ip = m_rd_ip + 16'd1;
            end
            if (m_req && ack) begin
                if (!m_abort) begin
                    if (m_ip % 2 == 0) begin
                        q.push_back(data[7:0]);
                        q.push_back(data[15:8]);
                        m_ip = m_ip + 16'd2;
                    end else begin
                        q.push_back(data[15:8]);
                        m_ip = m_ip + 16'd1;
                    end
                end
                m_abort = 1'b0;
                m_req   = 1'b0;
            end else if (!m_req && (DEPTH - sz) >= 2) begin
                phys   = (int'(m_cs) * 16 + int'(m_ip)) % 1048576;
                m_addr = 19'(phys / 2);
                m_req  = 1'b1;
            end
        end
        @(negedge clk);
        check_val("mem_access", {31'd0, mem_access}, {31'd0, m_req});
        if (m_req) check_val("mem_address", {13'd0, mem_address}, {13'd0, m_addr});
        check_val("fifo_empty", {31'd0, fifo_empty}, {31'd0, q.size() == 0});
        check_val("fifo_rd_ip", {16'd0, fifo_rd_ip}, {16'd0, m_rd_ip});
        if (q.size() > 0) check_val("fifo_rd_data", {24'd0, fifo_rd_data}, {24'd0, q[0]});
    endtask

    task automatic idle();
        tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !m_req; i++) idle();
        if (!m_req) check_val("wait_req_timeout", {31'd0, mem_access}, 32'd1);
    endtask

    task automatic ack_req(input logic [15:0] data);
        wait_req();
        tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, data);
    endtask

    task automatic settle();
        if (m_abort) ack_req(16'h0000);
    endtask

    task automatic load(input logic [15:0] cs, input logic [15:0] ip);
        tick(1'b1, cs, ip, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        reset_n = 1'b0;
        load_new_ip = 1'b0; new_cs = 16'h0000; new_ip = 16'h0000;
        fifo_rd_en = 1'b0; mem_ack = 1'b0; mem_data = 16'h0000;
        m_req = 1'b0; m_abort = 1'b0; m_addr = 19'h00000;
        m_cs = 16'hFFFF; m_ip = 16'h0000; m_rd_ip = 16'h0000;
        repeat (3) @(negedge clk);
        check_val("reset_access", {31'd0, mem_access}, 32'd0);
        check_val("reset_empty", {31'd0, fifo_empty}, 32'd1);
        check_val("reset_rd_ip", {16'd0, fifo_rd_ip}, 32'h0000);
        reset_n = 1'b1;

        // First fetch from FFFF:0000.
        idle();
        check_val("boot_addr", {13'd0, mem_address}, 32'h7FFF8);
        tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBBAA);
        check_val("boot_byte0", {24'd0, fifo_rd_data}, 32'hAA);
        check_val("boot_ip0", {16'd0, fifo_rd_ip}, 32'h0000);
        tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        check_val("boot_byte1", {24'd0, fifo_rd_data}, 32'hBB);
        check_val("boot_ip1", {16'd0, fifo_rd_ip}, 32'h0001);
        tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);

        // Odd IP: only the upper byte is queued.
        load(16'h0000, 16'h0003);
        settle();
        ack_req(16'h2211);
        check_val("odd_byte", {24'd0, fifo_rd_data}, 32'h22);
        check_val("odd_ip", {16'd0, fifo_rd_ip}, 32'h0003);
        wait_req();
        check_val("odd_next_addr", {13'd0, mem_address}, 32'h00002);

        // Fill the queue with no pops; fetching must stall until two slots free.
        load(16'h0000, 16'h0000);
        settle();
        for (int i = 0; i < 3; i++) ack_req(16'h1000 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            idle();
            check_val("full_stall", {31'd0, mem_access}, 32'd0);
        end
        tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        check_val("one_free_stall", {31'd0, mem_access}, 32'd0);
        tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000);
        check_val("two_free_pending", {31'd0, mem_access}, 32'd0);
        idle();
        check_val("two_free_issue", {31'd0, mem_access}, 32'd1);

        // Load while a request is outstanding: data dropped, refetch at the new address.
        load(16'h0000, 16'h0010);
        idle();
        idle();
        tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hDEAD);
        check_val("abort_empty", {31'd0, fifo_empty}, 32'd1);
        check_val("abort_access_low", {31'd0, mem_access}, 32'd0);
        idle();
        check_val("abort_new_addr", {13'd0, mem_address}, 32'h00008);

        // IP wraps within the segment without carrying into CS.
        load(16'h1000, 16'hFFFE);
        settle();
        wait_req();
        check_val("wrap_addr0", {13'd0, mem_address}, 32'h0FFFF);
        ack_req(16'h3344);
        wait_req();
        check_val("wrap_addr1", {13'd0, mem_address}, 32'h08000);

        // Load, pop and ack in the same cycle: load wins.
        tick(1'b1, 16'h0000, 16'h1234, 1'b1, 1'b1, 16'h5566);
        check_val("collide_empty", {31'd0, fifo_empty}, 32'd1);
        check_val("collide_rd_ip", {16'd0, fifo_rd_ip}, 32'h1234);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit ld;
            bit pop;
            bit ack;
            ld  = ($urandom_range(99) < 4);
            pop = ($urandom_range(99) < 50);
            ack = m_req && ($urandom_range(99) < 40);
            tick(ld, 16'($urandom), 16'($urandom), pop, ack, 16'($urandom));
        end

        // Asynchronous reset in the middle of a request.
        wait_req();
        #2 reset_n = 1'b0;
        #1;
        check_val("async_reset_access", {31'd0, mem_access}, 32'd0);
        check_val("async_reset_empty", {31'd0, fifo_empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
